// File: rtl/ones_run_pkg.sv
// Shared types and default sizing for the ones_run_gen serial pattern transmitter.
package ones_run_pkg;

   localparam int DEF_LEN_W    = 8;
   localparam int DEF_REP_W    = 4;
   localparam int DEF_DETECT_N = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DEF_LEN_W-1:0] run;
      logic [DEF_LEN_W-1:0] gap;
      logic [DEF_REP_W-1:0] rep;
   } cmd_t;

endpackage

// File: rtl/ones_run_tracker.sv
// Saturating consecutive-ones counter; flags each emitted 1 that completes a run of DETECT_N or more.
module ones_run_tracker
   import ones_run_pkg::*;
#(
   parameter int DETECT_N = DEF_DETECT_N
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic bit_i,
   input  logic bit_valid_i,
   input  logic clear_i,
   output logic expect_o
);

   localparam int CW = $clog2(DETECT_N + 1);
   localparam logic [CW-1:0] SAT = CW'(DETECT_N);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          expect_q, expect_d;

   // Saturating at DETECT_N makes "post-increment count >= DETECT_N" an equality test.
   always_comb begin
      cnt_d    = cnt_q;
      expect_d = 1'b0;
      if (clear_i || (bit_valid_i && !bit_i)) begin
         cnt_d = '0;
      end else if (bit_valid_i) begin
         cnt_d    = (cnt_q == SAT) ? cnt_q : cnt_q + CW'(1);
         expect_d = (cnt_d == SAT);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         expect_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expect_q <= expect_d;
      end
   end

   assign expect_o = expect_q;

endmodule

// File: rtl/ones_run_gen.sv
// Burst pattern transmitter: turns (run, gap, rep) commands into a registered serial bit stream with a golden Expect flag.
module ones_run_gen
   import ones_run_pkg::*;
#(
   parameter int LEN_W    = DEF_LEN_W,
   parameter int REP_W    = DEF_REP_W,
   parameter int DETECT_N = DEF_DETECT_N
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Cmd_valid,
   output logic             Cmd_ready,
   input  logic [LEN_W-1:0] Cmd_run,
   input  logic [LEN_W-1:0] Cmd_gap,
   input  logic [REP_W-1:0] Cmd_rep,
   output logic             Data,
   output logic             Expect,
   output logic             Busy,
   output logic             Done
);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] run_q, run_d;
   logic [LEN_W-1:0] gap_q, gap_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [LEN_W-1:0] pos_q, pos_d;
   logic             data_q, data_d;
   logic             done_q, done_d;
   logic             burst_end;

   assign Cmd_ready = (state_q == IDLE) && !Reset;

   // Data is computed one edge ahead so the bit for the next cycle is registered directly.
   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      gap_d     = gap_q;
      rep_d     = rep_q;
      pos_d     = pos_q;
      data_d    = 1'b0;
      done_d    = 1'b0;
      burst_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (Cmd_valid && Cmd_ready) begin
               run_d = Cmd_run;
               gap_d = Cmd_gap;
               rep_d = Cmd_rep;
               if (Cmd_run != '0) begin
                  state_d = RUN;
                  pos_d   = Cmd_run;
                  data_d  = 1'b1;
               end else if (Cmd_gap != '0) begin
                  state_d = GAP;
                  pos_d   = Cmd_gap;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (pos_q > LEN_W'(1)) begin
               pos_d  = pos_q - LEN_W'(1);
               data_d = 1'b1;
            end else if (gap_q != '0) begin
               state_d = GAP;
               pos_d   = gap_q;
            end else begin
               burst_end = 1'b1;
            end
         end
         GAP: begin
            if (pos_q > LEN_W'(1)) begin
               pos_d = pos_q - LEN_W'(1);
            end else begin
               burst_end = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (burst_end) begin
         if (rep_q != '0) begin
            rep_d = rep_q - REP_W'(1);
            if (run_q != '0) begin
               state_d = RUN;
               pos_d   = run_q;
               data_d  = 1'b1;
            end else begin
               state_d = GAP;
               pos_d   = gap_q;
            end
         end else begin
            state_d = IDLE;
            pos_d   = '0;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         run_q   <= '0;
         gap_q   <= '0;
         rep_q   <= '0;
         pos_q   <= '0;
         data_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         gap_q   <= gap_d;
         rep_q   <= rep_d;
         pos_q   <= pos_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   ones_run_tracker #(
      .DETECT_N (DETECT_N)
   ) u_tracker (
      .clk_i       (Clock),
      .rst_i       (Reset),
      .bit_i       (data_d),
      .bit_valid_i (state_d != IDLE),
      .clear_i     (state_d == IDLE),
      .expect_o    (Expect)
   );

   assign Data = data_q;
   assign Busy = (state_q != IDLE);
   assign Done = done_q;

endmodule

// File: tb/tb_ones_run_gen.sv
// Self-checking bench for ones_run_gen: stream-level reference model plus directed literal patterns and random commands.
module tb_ones_run_gen;
   import ones_run_pkg::*;

   localparam int DN = DEF_DETECT_N;

   logic                 Clock = 1'b0;
   logic                 Reset = 1'b1;
   logic                 Cmd_valid = 1'b0;
   logic                 Cmd_ready;
   logic [DEF_LEN_W-1:0] Cmd_run = '0;
   logic [DEF_LEN_W-1:0] Cmd_gap = '0;
   logic [DEF_REP_W-1:0] Cmd_rep = '0;
   logic                 Data, Expect, Busy, Done;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   ones_run_gen #(
      .LEN_W    (DEF_LEN_W),
      .REP_W    (DEF_REP_W),
      .DETECT_N (DN)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Cmd_valid (Cmd_valid),
      .Cmd_ready (Cmd_ready),
      .Cmd_run   (Cmd_run),
      .Cmd_gap   (Cmd_gap),
      .Cmd_rep   (Cmd_rep),
      .Data      (Data),
      .Expect    (Expect),
      .Busy      (Busy),
      .Done      (Done)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each accepted command expands into its full bit list up front.
   bit [1:0] q[$];
   bit       m_busy = 1'b0;
   bit       m_data = 1'b0;
   bit       m_exp  = 1'b0;
   bit       m_done = 1'b0;

   task automatic expand(input cmd_t c);
      int cnt = 0;
      for (int b = 0; b <= int'(c.rep); b++) begin
         for (int i = 0; i < int'(c.run); i++) begin
            cnt++;
            q.push_back({1'b1, cnt >= DN});
         end
         for (int i = 0; i < int'(c.gap); i++) begin
            cnt = 0;
            q.push_back(2'b00);
         end
      end
   endtask

   always @(posedge Clock) begin
      bit [1:0] e;
      cmd_t     c;
      if (Reset) begin
         q.delete();
         m_busy = 1'b0; m_data = 1'b0; m_exp = 1'b0; m_done = 1'b0;
      end else if (m_busy) begin
         m_done = 1'b0;
         if (q.size() > 0) begin
            e = q.pop_front();
            m_data = e[1]; m_exp = e[0];
         end else begin
            m_busy = 1'b0; m_data = 1'b0; m_exp = 1'b0; m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0; m_data = 1'b0; m_exp = 1'b0;
         if (Cmd_valid) begin
            c.run = Cmd_run; c.gap = Cmd_gap; c.rep = Cmd_rep;
            expand(c);
            if (q.size() == 0) begin
               m_done = 1'b1;
            end else begin
               e = q.pop_front();
               m_data = e[1]; m_exp = e[0]; m_busy = 1'b1;
            end
         end
      end
   end

   always @(negedge Clock) begin
      if (chk_en) begin
         chk("data",   64'(Data),      64'(m_data));
         chk("expect", 64'(Expect),    64'(m_exp));
         chk("busy",   64'(Busy),      64'(m_busy));
         chk("done",   64'(Done),      64'(m_done));
         chk("ready",  64'(Cmd_ready), 64'(!Reset && !m_busy));
      end
   end

   task automatic wait_accept(input string nm, output bit ok);
      bit rdy;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clock);
         rdy = Cmd_ready;
         @(posedge Clock);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({nm, "_accept_timeout"}, 64'(0), 64'(1));
   endtask

   // Issues one command, scrambles the fields while busy, and pins L bits of DUT and model to literals.
   task automatic run_cmd(input int r, input int g, input int p,
                          input logic [63:0] eD, input logic [63:0] eE,
                          input int L, input string nm);
      logic [63:0] capD = '0, capE = '0, mD = '0, mE = '0;
      bit ok;
      @(posedge Clock); #1;
      Cmd_run = DEF_LEN_W'(r); Cmd_gap = DEF_LEN_W'(g); Cmd_rep = DEF_REP_W'(p);
      Cmd_valid = 1'b1;
      wait_accept(nm, ok);
      if (!ok) begin Cmd_valid = 1'b0; return; end
      #1;
      Cmd_valid = 1'b0;
      Cmd_run = DEF_LEN_W'($urandom); Cmd_gap = DEF_LEN_W'($urandom); Cmd_rep = DEF_REP_W'($urandom);
      for (int k = 0; k < L; k++) begin
         @(negedge Clock);
         capD = {capD[62:0], Data};   capE = {capE[62:0], Expect};
         mD   = {mD[62:0], m_data};   mE   = {mE[62:0], m_exp};
      end
      chk({nm, "_data"},       capD, eD);
      chk({nm, "_expect"},     capE, eE);
      chk({nm, "_model_data"}, mD,   eD);
      chk({nm, "_model_exp"},  mE,   eE);
      @(negedge Clock);
      chk({nm, "_done_end"},  64'(Done),      64'(1));
      chk({nm, "_busy_end"},  64'(Busy),      64'(0));
      chk({nm, "_ready_end"}, 64'(Cmd_ready), 64'(1));
   endtask

   initial begin
      logic [63:0] capD, capE, capDone;
      bit ok;
      int r, g, p, L;

      Reset = 1'b1;
      @(posedge Clock);
      chk_en = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      chk("reset_data",  64'(Data),      64'(0));
      chk("reset_busy",  64'(Busy),      64'(0));
      chk("reset_ready", 64'(Cmd_ready), 64'(0));
      #1 Reset = 1'b0;

      run_cmd(5, 2, 0, 64'b1111100, 64'b0011100, 7, "basic");
      run_cmd(2, 0, 2, 64'b111111, 64'b001111, 6, "merged");
      run_cmd(2, 1, 3, 64'b110110110110, 64'b0, 12, "short");
      run_cmd(0, 0, 0, 64'b0, 64'b0, 0, "zero");
      run_cmd(0, 3, 1, 64'b000000, 64'b0, 6, "gaponly");
      run_cmd(1, 0, 15, 64'hFFFF, 64'h3FFF, 16, "rep_max");

      // Back-to-back: valid held high across two identical commands.
      @(posedge Clock); #1;
      Cmd_run = 8'd3; Cmd_gap = 8'd0; Cmd_rep = 4'd0; Cmd_valid = 1'b1;
      wait_accept("b2b", ok);
      capD = '0; capE = '0; capDone = '0;
      for (int k = 0; k < 7; k++) begin
         @(negedge Clock);
         capD = {capD[62:0], Data}; capE = {capE[62:0], Expect}; capDone = {capDone[62:0], Done};
      end
      Cmd_valid = 1'b0;
      chk("b2b_data",   capD,    64'b1110111);
      chk("b2b_expect", capE,    64'b0010001);
      chk("b2b_done",   capDone, 64'b0001000);
      repeat (4) @(posedge Clock);

      // Reset during bit 4 of a 10-bit run.
      @(posedge Clock); #1;
      Cmd_run = 8'd10; Cmd_gap = 8'd0; Cmd_rep = 4'd0; Cmd_valid = 1'b1;
      wait_accept("rstmid", ok);
      #1 Cmd_valid = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      chk("rstmid_expect_b4", 64'(Expect), 64'(1));
      #1 Reset = 1'b1;
      @(posedge Clock); #1 Reset = 1'b0;
      @(negedge Clock);
      chk("rstmid_data",   64'(Data),   64'(0));
      chk("rstmid_expect", 64'(Expect), 64'(0));
      chk("rstmid_busy",   64'(Busy),   64'(0));
      capDone = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         capDone = {capDone[62:0], Done};
      end
      chk("rstmid_no_done", capDone, 64'b0);
      run_cmd(3, 0, 0, 64'b111, 64'b001, 3, "after_rst");

      // Random commands; the per-cycle compare against the model does the checking.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge Clock);
         #1;
         r = $urandom_range(0, 5); g = $urandom_range(0, 3); p = $urandom_range(0, 15);
         L = (p + 1) * (r + g);
         Cmd_run = DEF_LEN_W'(r); Cmd_gap = DEF_LEN_W'(g); Cmd_rep = DEF_REP_W'(p);
         Cmd_valid = 1'b1;
         wait_accept("rand", ok);
         #1;
         Cmd_valid = ($urandom_range(0, 3) == 0);
         for (int k = 0; k <= L; k++) begin
            Cmd_run = DEF_LEN_W'($urandom_range(0, 5));
            Cmd_gap = DEF_LEN_W'($urandom_range(0, 3));
            Cmd_rep = DEF_REP_W'($urandom_range(0, 3));
            @(posedge Clock); #1;
         end
         Cmd_valid = 1'b0;
         for (int k = 0; k < 200 && m_busy; k++) @(posedge Clock);
         if (m_busy) chk("rand_drain_timeout", 64'(m_busy), 64'(0));
      end

      repeat (3) @(posedge Clock);
      @(negedge Clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
